// File: rtl/mu0_control_if.sv
// Memory-port handshake between the MU0 sequencer and the memory.
interface mu0_control_if;
    logic Mem_Rd;
    logic Mem_Wr;
    logic Addr_Sel;
    logic Mem_Ack;

    modport master (output Mem_Rd, output Mem_Wr, output Addr_Sel, input Mem_Ack);
    modport slave  (input Mem_Rd, input Mem_Wr, input Addr_Sel, output Mem_Ack);
endinterface

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer: decodes F, drives datapath enables, mux selects,
// ALU function and memory strobes, with an access watchdog and instruction counter.
module mu0_control #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  F,
    input  logic        N,
    input  logic        Z,
    input  logic        Start,
    mu0_control_if.master bus,
    output logic        Acc_En,
    output logic        PC_En,
    output logic        IR_En,
    output logic        PC_Sel,
    output logic [1:0]  ALU_Fn,
    output logic        Fetch,
    output logic        Halted,
    output logic        Bus_Err,
    output logic [15:0] Icount
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Timeout fires on the cycle whose wait would bring the counter to WAIT_MAX.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state, state_nxt;
    logic [7:0]  wcnt, wcnt_nxt;
    logic [15:0] icount_r;
    logic        err_r;

    logic        acc_en_c, pc_en_c, ir_en_c, addr_sel_c, pc_sel_c, rd_c, wr_c;
    logic [1:0]  fn_c;
    logic        done_c, set_err_c, clr_err_c, waiting_c;

    always_comb begin
        state_nxt  = state;
        acc_en_c   = 1'b0;
        pc_en_c    = 1'b0;
        ir_en_c    = 1'b0;
        addr_sel_c = 1'b0;
        pc_sel_c   = 1'b0;
        rd_c       = 1'b0;
        wr_c       = 1'b0;
        fn_c       = 2'b00;
        done_c     = 1'b0;
        set_err_c  = 1'b0;
        clr_err_c  = 1'b0;
        waiting_c  = 1'b0;
        wcnt_nxt   = wcnt;

        case (state)
            FETCH: begin
                rd_c = 1'b1;
                fn_c = 2'b11;
                if (bus.Mem_Ack) begin
                    ir_en_c   = 1'b1;
                    pc_en_c   = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                case (F)
                    4'd0: begin addr_sel_c = 1'b1; rd_c = 1'b1; acc_en_c = bus.Mem_Ack; end
                    4'd1: begin addr_sel_c = 1'b1; wr_c = 1'b1; end
                    4'd2: begin
                        addr_sel_c = 1'b1; rd_c = 1'b1; fn_c = 2'b01; acc_en_c = bus.Mem_Ack;
                    end
                    4'd3: begin
                        addr_sel_c = 1'b1; rd_c = 1'b1; fn_c = 2'b10; acc_en_c = bus.Mem_Ack;
                    end
                    4'd4: begin pc_sel_c = 1'b1; pc_en_c = 1'b1; end
                    4'd5: begin pc_sel_c = 1'b1; pc_en_c = ~N; end
                    4'd6: begin pc_sel_c = 1'b1; pc_en_c = ~Z; end
                    default: ;
                endcase
                if (F[3:2] == 2'b00) begin
                    if (bus.Mem_Ack) begin
                        state_nxt = FETCH;
                        done_c    = 1'b1;
                    end
                end else begin
                    state_nxt = (F == 4'd7) ? HALT : FETCH;
                    done_c    = 1'b1;
                end
            end
            HALT: begin
                if (Start) begin
                    state_nxt = FETCH;
                    clr_err_c = 1'b1;
                end
            end
            default: state_nxt = FETCH;
        endcase

        // An unacknowledged access that runs out of budget aborts to HALT;
        // a same-cycle Mem_Ack never reaches this branch.
        waiting_c = (rd_c | wr_c) & ~bus.Mem_Ack;
        if (waiting_c && (wcnt == WAIT_LAST)) begin
            state_nxt = HALT;
            set_err_c = 1'b1;
        end

        if ((state_nxt != state) || bus.Mem_Ack)
            wcnt_nxt = 8'd0;
        else if (waiting_c)
            wcnt_nxt = wcnt + 8'd1;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= FETCH;
            wcnt     <= 8'd0;
            icount_r <= 16'd0;
            err_r    <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (done_c)
                icount_r <= icount_r + 16'd1;
            if (set_err_c)
                err_r <= 1'b1;
            else if (clr_err_c)
                err_r <= 1'b0;
        end
    end

    // Reset gates the decode combinationally so strobes drop without a clock edge.
    assign Acc_En       = acc_en_c   & Reset;
    assign PC_En        = pc_en_c    & Reset;
    assign IR_En        = ir_en_c    & Reset;
    assign PC_Sel       = pc_sel_c   & Reset;
    assign ALU_Fn       = fn_c       & {2{Reset}};
    assign bus.Addr_Sel = addr_sel_c & Reset;
    assign bus.Mem_Rd   = rd_c       & Reset;
    assign bus.Mem_Wr   = wr_c       & Reset;

    assign Fetch   = (state == FETCH);
    assign Halted  = (state == HALT);
    assign Bus_Err = err_r;
    assign Icount  = icount_r;

endmodule

// File: tb/tb_mu0_control.sv
// Table-driven, scoreboard-checked bench for the MU0 sequencer.
module tb_mu0_control;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  F = 4'd0;
    logic        N = 1'b0;
    logic        Z = 1'b0;
    logic        Start = 1'b0;
    logic        Acc_En, PC_En, IR_En, PC_Sel, Fetch, Halted, Bus_Err;
    logic [1:0]  ALU_Fn;
    logic [15:0] Icount;

    mu0_control_if bus();

    mu0_control #(.WAIT_MAX(15)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .F       (F),
        .N       (N),
        .Z       (Z),
        .Start   (Start),
        .bus     (bus),
        .Acc_En  (Acc_En),
        .PC_En   (PC_En),
        .IR_En   (IR_En),
        .PC_Sel  (PC_Sel),
        .ALU_Fn  (ALU_Fn),
        .Fetch   (Fetch),
        .Halted  (Halted),
        .Bus_Err (Bus_Err),
        .Icount  (Icount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0]  f;
        logic        n;
        logic        z;
        logic        ack;
        logic        start;
        logic [11:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] exp_q[$];
    string       name_q[$];
    int          nvec = 0;
    int          nerr = 0;

    // {Acc_En,PC_En,IR_En,Addr_Sel,PC_Sel,ALU_Fn,Mem_Rd,Mem_Wr,Fetch,Halted,Bus_Err}
    function automatic logic [11:0] mk(input bit acc, pc, ir, as, ps, input bit [1:0] fn,
                                       input bit rd, wr, fe, ha, er);
        return {acc, pc, ir, as, ps, fn, rd, wr, fe, ha, er};
    endfunction

    function automatic logic [11:0] outs();
        return {Acc_En, PC_En, IR_En, bus.Addr_Sel, PC_Sel, ALU_Fn,
                bus.Mem_Rd, bus.Mem_Wr, Fetch, Halted, Bus_Err};
    endfunction

    function automatic vec_t v(input logic [3:0] f, input logic n, z, ack, start,
                               input logic [11:0] e);
        vec_t r;
        r.f = f; r.n = n; r.z = z; r.ack = ack; r.start = start; r.exp = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare on the falling edge.
    task automatic apply(input logic [3:0] f, input logic n, z, ack, start,
                         input logic [11:0] e, input string nm);
        logic [11:0] ex;
        string       en;
        F = f; N = n; Z = z; bus.Mem_Ack = ack; Start = start;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge Clk);
        if (exp_q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            ex = exp_q.pop_front();
            en = name_q.pop_front();
            chk(en, {4'h0, outs()}, {4'h0, ex});
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] fa, fw, hlt, zero, lda;
        fa   = mk(0,1,1,0,0,2'b11,1,0,1,0,0);
        fw   = mk(0,0,0,0,0,2'b11,1,0,1,0,0);
        hlt  = mk(0,0,0,0,0,2'b00,0,0,0,1,0);
        zero = mk(0,0,0,0,0,2'b00,0,0,0,0,0);
        lda  = mk(0,0,0,1,0,2'b00,1,0,0,0,0);

        tbl.push_back(v(4'd0,0,0,1,0,fa));
        tbl.push_back(v(4'd0,0,0,1,0,mk(1,0,0,1,0,2'b00,1,0,0,0,0)));
        tbl.push_back(v(4'd2,0,0,1,0,fa));
        tbl.push_back(v(4'd2,0,0,1,0,mk(1,0,0,1,0,2'b01,1,0,0,0,0)));
        tbl.push_back(v(4'd3,0,0,1,0,fa));
        tbl.push_back(v(4'd3,0,0,1,0,mk(1,0,0,1,0,2'b10,1,0,0,0,0)));
        tbl.push_back(v(4'd1,0,0,1,0,fa));
        tbl.push_back(v(4'd1,0,0,1,0,mk(0,0,0,1,0,2'b00,0,1,0,0,0)));
        tbl.push_back(v(4'd7,0,0,1,0,fa));
        tbl.push_back(v(4'd7,0,0,1,0,zero));
        tbl.push_back(v(4'd7,0,0,1,0,hlt));
        tbl.push_back(v(4'd7,0,0,1,1,hlt));
        tbl.push_back(v(4'd5,1,0,1,0,fa));
        tbl.push_back(v(4'd5,1,0,1,0,mk(0,0,0,0,1,2'b00,0,0,0,0,0)));
        tbl.push_back(v(4'd5,0,0,1,0,fa));
        tbl.push_back(v(4'd5,0,0,1,0,mk(0,1,0,0,1,2'b00,0,0,0,0,0)));
        tbl.push_back(v(4'd6,0,1,1,0,fa));
        tbl.push_back(v(4'd6,0,1,1,0,mk(0,0,0,0,1,2'b00,0,0,0,0,0)));
        tbl.push_back(v(4'd6,0,0,1,0,fa));
        tbl.push_back(v(4'd6,0,0,1,0,mk(0,1,0,0,1,2'b00,0,0,0,0,0)));
        tbl.push_back(v(4'd4,1,1,1,0,fa));
        tbl.push_back(v(4'd4,1,1,1,0,mk(0,1,0,0,1,2'b00,0,0,0,0,0)));

        bus.Mem_Ack = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_outs", {4'h0, outs()}, {4'h0, mk(0,0,0,0,0,2'b00,0,0,1,0,0)});
        chk("reset_icount", Icount, 16'h0000);
        @(negedge Clk);
        #2 Reset = 1'b1;
        @(posedge Clk);
        #1;

        // One NOP completes, then an ADD is caught mid-EXEC by reset.
        apply(4'd8, 0, 0, 1, 0, fa, "nop_fetch");
        apply(4'd8, 0, 0, 1, 0, zero, "nop_exec");
        chk("icount_pre_rst", Icount, 16'h0001);
        apply(4'd2, 0, 0, 1, 0, fa, "add_fetch");
        apply(4'd2, 0, 0, 0, 0, mk(0,0,0,1,0,2'b01,1,0,0,0,0), "add_wait");
        #2 Reset = 1'b0;
        #1;
        chk("rst_async", {10'h0, Acc_En, PC_En, IR_En, bus.Mem_Rd, bus.Mem_Wr, Fetch},
            16'h0001);
        @(posedge Clk);
        #3 Reset = 1'b1;
        #1;
        chk("rst_release", {13'h0, Fetch, Halted, Bus_Err}, 16'h0004);
        chk("rst_icount", Icount, 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].f, tbl[i].n, tbl[i].z, tbl[i].ack, tbl[i].start, tbl[i].exp,
                  $sformatf("tbl[%0d]", i));
            if (tbl[i].exp[1])
                chk($sformatf("tbl[%0d]_icount", i), Icount, 16'd5);
        end
        chk("icount_jumps", Icount, 16'd10);

        for (int i = 0; i < 3; i++)
            apply(4'd8, 0, 0, 0, 0, fw, $sformatf("fetch_wait%0d", i));
        apply(4'd8, 0, 0, 1, 0, fa, "fetch_ack");
        apply(4'd8, 0, 0, 0, 0, zero, "nop8_exec");
        chk("icount_nop", Icount, 16'd11);

        // Mem_Ack on the last permitted wait cycle completes normally.
        apply(4'd0, 0, 0, 1, 0, fa, "lda_edge_fetch");
        for (int i = 0; i < 14; i++)
            apply(4'd0, 0, 0, 0, 0, lda, $sformatf("lda_edge_wait%0d", i));
        apply(4'd0, 0, 0, 1, 0, mk(1,0,0,1,0,2'b00,1,0,0,0,0), "lda_edge_ack");
        apply(4'd0, 0, 0, 0, 0, fw, "edge_no_err");
        chk("icount_edge", Icount, 16'd12);

        apply(4'd0, 0, 0, 1, 0, fa, "lda_to_fetch");
        for (int i = 0; i < 15; i++)
            apply(4'd0, 0, 0, 0, 0, lda, $sformatf("lda_to_wait%0d", i));
        apply(4'd0, 0, 0, 0, 0, mk(0,0,0,0,0,2'b00,0,0,0,1,1), "to_halt");
        chk("icount_to", Icount, 16'd12);
        apply(4'd0, 0, 0, 0, 1, mk(0,0,0,0,0,2'b00,0,0,0,1,1), "to_start");
        apply(4'd0, 0, 0, 0, 0, fw, "to_refetch");

        force dut.icount_r = 16'hFFF8;
        #2;
        release dut.icount_r;
        for (int k = 0; k < 8; k++) begin
            apply(4'(8 + k), 0, 0, 1, 0, fa, $sformatf("wrap_fetch%0d", k));
            apply(4'(8 + k), 1, 1, 1, 0, zero, $sformatf("wrap_nop%0d", 8 + k));
            if (k == 6)
                chk("icount_ffff", Icount, 16'hFFFF);
        end
        chk("icount_wrap", Icount, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
